// File: rtl/mem_ram_if.sv
// mem_ram bus: valid/ready request channel with byte strobes.
// Initiator holds addr/wdata/wstrb stable from accept to ready.
interface mem_ram_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_err;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata, mem_err
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata, mem_err
  );
endinterface

// File: rtl/mem_ram.sv
// Wait-state SRAM target with byte strobes and a one-cycle ready pulse.
// MEM_RAM_OOR_RESP_EN: answer out-of-range requests with rdata 0 and sticky mem_err.
module mem_ram #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic      clk,
  input  logic      rstn,
  mem_ram_if.slave  bus
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   rdata_q;
  logic          fire;
  logic          in_range;
  logic          accept_ok;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          unused;

  logic [31:0] mem [DEPTH_WORDS];

  assign off      = bus.mem_addr - BASE_ADDR;
  assign in_range = (bus.mem_addr >= BASE_ADDR)
                 && ({1'b0, off} < SPAN);
  assign idx      = off[AW+1:2];
  assign unused   = ^{off[31:AW+2], off[1:0]};

`ifdef MEM_RAM_OOR_RESP_EN
  logic err_q;
  assign accept_ok   = 1'b1;
  assign bus.mem_err = err_q;
`else
  assign accept_ok   = in_range;
  assign bus.mem_err = 1'b0;
`endif

  assign bus.mem_ready = (state_q == RESP);
  assign bus.mem_rdata = rdata_q;

  // fire marks the edge that enters RESP: the access happens there
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_valid && accept_ok) begin
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            fire    = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!bus.mem_valid) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = RESP;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fire && !in_range)
        rdata_q <= 32'h0;
      else if (fire && bus.mem_wstrb == 4'b0000)
        rdata_q <= mem[idx];
    end
  end

`ifdef MEM_RAM_OOR_RESP_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      err_q <= 1'b0;
    else if (state_q == IDLE && bus.mem_valid && !in_range)
      err_q <= 1'b1;
  end
`endif

  // contents survive reset
  always_ff @(posedge clk) begin
    if (fire && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.mem_wstrb[i])
          mem[idx][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_ram.sv
// Directed bench for mem_ram: dut1 has WAIT_STATES=1, dut0 has WAIT_STATES=0.
// Expected values are hand-computed constants.
module tb_mem_ram;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  mem_ram_if b1();
  mem_ram_if b0();

  mem_ram #(.WAIT_STATES(1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b1)
  );

  mem_ram #(.WAIT_STATES(0)) dut0 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input bit sel, input logic v,
                       input logic [31:0] a, input logic [31:0] w,
                       input logic [3:0] s);
    if (sel) begin
      b0.mem_valid = v; b0.mem_addr = a;
      b0.mem_wdata = w; b0.mem_wstrb = s;
    end else begin
      b1.mem_valid = v; b1.mem_addr = a;
      b1.mem_wdata = w; b1.mem_wstrb = s;
    end
  endtask

  // lat = edges from accept to ready seen (accept edge counts 1); -1 on timeout
  task automatic do_req(input bit sel, input logic [31:0] a,
                        input logic [31:0] w, input logic [3:0] s,
                        output int lat, output logic [31:0] rd);
    logic r;
    lat = -1;
    rd  = 32'h0;
    @(negedge clk);
    drive(sel, 1'b1, a, w, s);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      r = sel ? b0.mem_ready : b1.mem_ready;
      if (r) begin
        lat = n;
        rd  = sel ? b0.mem_rdata : b1.mem_rdata;
        break;
      end
    end
    drive(sel, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    checks++;
    if (b1.mem_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b want 0", b1.mem_ready);
    end
    checks++;
    if (b1.mem_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h want 0", b1.mem_rdata);
    end
    checks++;
    if (b1.mem_err !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b want 0", b1.mem_err);
    end
    checks++;
    if (b0.mem_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready0 got %b want 0", b0.mem_ready);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    int lat;
    logic [31:0] rd;
    do_req(1'b0, 32'h0001_0010, 32'hCAFE_F00D, 4'hF, lat, rd);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL wr_latency got %0d want 2", lat);
    end
    do_req(1'b0, 32'h0001_0010, 32'h0, 4'h0, lat, rd);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL rd_latency got %0d want 2", lat);
    end
    checks++;
    if (rd !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL rd_data got %h want cafef00d", rd);
    end
  endtask

  task automatic test_strobe;
    int lat;
    logic [31:0] rd;
    do_req(1'b0, 32'h0001_0020, 32'h1122_3344, 4'hF, lat, rd);
    checks++;
    if (b1.mem_rdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL rdata_hold got %h want cafef00d", b1.mem_rdata);
    end
    do_req(1'b0, 32'h0001_0020, 32'hAABB_CCDD, 4'b0101, lat, rd);
    do_req(1'b0, 32'h0001_0020, 32'h0, 4'h0, lat, rd);
    checks++;
    if (rd !== 32'h11BB_33DD) begin
      errors++; $display("FAIL strobe got %h want 11bb33dd", rd);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] rd, r1, r3;
    logic [3:0] seen;
    do_req(1'b1, 32'h0001_0000, 32'hA5A5_0001, 4'hF, lat, rd);
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL ws0_latency got %0d want 1", lat);
    end
    do_req(1'b1, 32'h0001_0004, 32'h5A5A_0004, 4'hF, lat, rd);
    seen = 4'h0;
    r1 = 32'h0;
    r3 = 32'h0;
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h0001_0000, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      seen[i] = b0.mem_ready;
      if (i == 0) begin
        r1 = b0.mem_rdata;
        b0.mem_addr = 32'h0001_0004;
      end
      if (i == 2) begin
        r3 = b0.mem_rdata;
        b0.mem_valid = 1'b0;
      end
    end
    checks++;
    if (seen !== 4'b0101) begin
      errors++; $display("FAIL b2b_pulses got %b want 0101", seen);
    end
    checks++;
    if (r1 !== 32'hA5A5_0001) begin
      errors++; $display("FAIL b2b_rd1 got %h want a5a50001", r1);
    end
    checks++;
    if (r3 !== 32'h5A5A_0004) begin
      errors++; $display("FAIL b2b_rd2 got %h want 5a5a0004", r3);
    end
  endtask

  task automatic test_oor;
    int lat;
    logic [31:0] rd;
    do_req(1'b0, 32'h0001_0FFC, 32'h7E7E_7E7E, 4'hF, lat, rd);
    do_req(1'b0, 32'h0001_0FFC, 32'h0, 4'h0, lat, rd);
    checks++;
    if (rd !== 32'h7E7E_7E7E || lat !== 2) begin
      errors++; $display("FAIL last_word got %h/%0d want 7e7e7e7e/2", rd, lat);
    end
    checks++;
    if (b1.mem_err !== 1'b0) begin
      errors++; $display("FAIL err_in_range got %b want 0", b1.mem_err);
    end
    do_req(1'b0, 32'h0000_0000, 32'h0, 4'h0, lat, rd);
`ifdef MEM_RAM_OOR_RESP_EN
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL oor_latency got %0d want 2", lat);
    end
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL oor_rdata got %h want 0", rd);
    end
    checks++;
    if (b1.mem_err !== 1'b1) begin
      errors++; $display("FAIL oor_err got %b want 1", b1.mem_err);
    end
    do_req(1'b0, 32'h0001_1000, 32'h0, 4'h0, lat, rd);
    checks++;
    if (lat !== 2 || rd !== 32'h0) begin
      errors++; $display("FAIL oor_top got %0d/%h want 2/0", lat, rd);
    end
`else
    checks++;
    if (lat !== -1) begin
      errors++; $display("FAIL oor_ignored got %0d want -1", lat);
    end
    checks++;
    if (b1.mem_err !== 1'b0) begin
      errors++; $display("FAIL oor_err got %b want 0", b1.mem_err);
    end
    do_req(1'b0, 32'h0001_1000, 32'h0, 4'h0, lat, rd);
    checks++;
    if (lat !== -1) begin
      errors++; $display("FAIL oor_top got %0d want -1", lat);
    end
`endif
  endtask

  task automatic test_reset_mid_wait;
    int lat;
    int hits;
    logic [31:0] rd;
    do_req(1'b0, 32'h0001_0030, 32'h1234_5678, 4'hF, lat, rd);
    do_req(1'b0, 32'h0001_0030, 32'h0, 4'h0, lat, rd);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0001_0030, 32'hDEAD_BEEF, 4'hF);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if (b1.mem_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_wait_rdata got %h want 0", b1.mem_rdata);
    end
    checks++;
    if (b1.mem_err !== 1'b0) begin
      errors++; $display("FAIL rst_wait_err got %b want 0", b1.mem_err);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    hits = 0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (b1.mem_ready) hits++;
    end
    checks++;
    if (hits !== 0) begin
      errors++; $display("FAIL rst_wait_ready got %0d pulses want 0", hits);
    end
    do_req(1'b0, 32'h0001_0030, 32'h0, 4'h0, lat, rd);
    checks++;
    if (rd !== 32'h1234_5678) begin
      errors++; $display("FAIL rst_wait_word got %h want 12345678", rd);
    end
  endtask

  task automatic test_abort;
    int lat;
    int hits;
    logic [31:0] rd;
    do_req(1'b0, 32'h0001_0040, 32'h0101_0101, 4'hF, lat, rd);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0001_0040, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0001_0040, 32'hFFFF_FFFF, 4'hF);
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (b1.mem_ready) hits++;
    end
    checks++;
    if (hits !== 0) begin
      errors++; $display("FAIL abort_ready got %0d pulses want 0", hits);
    end
    do_req(1'b0, 32'h0001_0040, 32'h0, 4'h0, lat, rd);
    checks++;
    if (rd !== 32'h0101_0101) begin
      errors++; $display("FAIL abort_word got %h want 01010101", rd);
    end
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL abort_next_lat got %0d want 2", lat);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_strobe();
    test_back_to_back();
    test_oor();
    test_reset_mid_wait();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/mem_ram.md
MEM_RAM -- requirements
Module: mem_ram

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0001_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words (power of two).
REQ-003 SHALL have parameter WAIT_STATES, default 1, extra cycles inserted before mem_ready (0..15).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port mem_valid  input  1  initiator request pending.
REQ-007 SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-008 SHALL have port mem_addr  input  32  byte address; bits [1:0] ignored.
REQ-009 SHALL have port mem_rdata  output  32  read data, valid while mem_ready=1.
REQ-010 SHALL have port mem_wdata  input  32  write data.
REQ-011 SHALL have port mem_wstrb  input  4  byte write enables; 4'b0000 = read.
REQ-012 SHALL have port mem_err  output  1  sticky out-of-range flag.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 IDLE: on an edge with mem_valid=1 and address in range [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS), SHALL accept: go to RESP if WAIT_STATES=0, else load wait counter with WAIT_STATES-1 and go to WAIT.
REQ-015 WAIT: SHALL decrement the counter each cycle; when it reaches 0, SHALL go to RESP.
REQ-016 On the transition into RESP, SHALL execute the access: a write updates only the byte lanes with mem_wstrb[i]=1, taking mem_wdata[8i+7:8i]; a read loads mem_rdata with the addressed word.
REQ-017 mem_ready SHALL be 1 exactly during RESP (one cycle), then the FSM returns to IDLE.
REQ-018 Latency: with mem_valid first high at accept edge E0, mem_ready SHALL be high in cycle E0+1+WAIT_STATES.
REQ-019 mem_rdata SHALL hold its last read value through writes and idle cycles.
REQ-020 Word index SHALL be (mem_addr-BASE_ADDR)>>2; no wrap-around beyond DEPTH_WORDS.
REQ-021 mem_valid=1 on the cycle after RESP SHALL be treated as a new request (back-to-back, one IDLE cycle between ready pulses).
REQ-022 mem_valid dropping in WAIT (protocol violation) SHALL abort: return to IDLE, no write, no ready.
REQ-023 Initiator SHALL hold mem_addr/mem_wdata/mem_wstrb stable from accept to ready; the block samples them at the RESP edge.

Reset
REQ-024 rstn=0 SHALL immediately force state IDLE, mem_ready=0, mem_rdata=0, mem_err=0, wait counter=0.
REQ-025 Reset mid-WAIT SHALL cancel the access with no write; memory contents SHALL NOT be cleared by reset.

Configuration
REQ-026 Macro MEM_RAM_OOR_RESP_EN defined: out-of-range requests SHALL be accepted with the same latency, writes dropped, mem_rdata=32'h0000_0000 at ready, and mem_err set to 1 until reset.
REQ-027 Macro MEM_RAM_OOR_RESP_EN undefined: out-of-range requests SHALL be ignored (no ready, FSM stays IDLE) so another responder may answer; mem_err SHALL be tied 0.

Verification
REQ-028 WAIT_STATES=1: write 32'hCAFE_F00D, wstrb 4'hF, addr 32'h0001_0010 -> ready 2 cycles after accept; subsequent read returns 32'hCAFE_F00D with ready 2 cycles after accept.
REQ-029 Word holds 32'h1122_3344; write wdata 32'hAABB_CCDD wstrb 4'b0101 -> read returns 32'h11BB_33DD.
REQ-030 WAIT_STATES=0: two back-to-back reads of 0x0001_0000 and 0x0001_0004 -> ready pulses in cycles 1 and 3, exactly one cycle each.
REQ-031 Read addr 32'h0000_0000: with macro -> ready after 1+WAIT_STATES, rdata 0, mem_err=1; without macro -> no ready within 20 cycles, mem_err=0.
REQ-032 Write issued, rstn pulsed low during WAIT -> mem_ready stays 0, mem_rdata=0, target word unchanged on later read.
REQ-033 mem_valid deasserted in WAIT -> no ready, no write; next valid request completes normally.
